// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operation sequencer.
// Operand-select codes are active-low one-hot onto the R0..R3/PC latch enables.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL1 = 3'd1,
        SEL2 = 3'd2,
        EXEC = 3'd3,
        WAIT = 3'd4,
        WB   = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [2:0] SRC_R0 = 3'd0;
    localparam logic [2:0] SRC_R1 = 3'd1;
    localparam logic [2:0] SRC_R2 = 3'd2;
    localparam logic [2:0] SRC_R3 = 3'd3;
    localparam logic [2:0] SRC_PC = 3'd4;

    localparam logic [4:0] SEL_R0   = 5'b11110;
    localparam logic [4:0] SEL_R1   = 5'b11101;
    localparam logic [4:0] SEL_R2   = 5'b11011;
    localparam logic [4:0] SEL_R3   = 5'b10111;
    localparam logic [4:0] SEL_PC   = 5'b01111;
    localparam logic [4:0] SEL_NONE = 5'b11111;

    function automatic logic src_is_legal(input logic [2:0] src);
        return (src <= SRC_PC);
    endfunction

endpackage

// File: rtl/calc_src_decode.sv
// Operand source decoder: 3-bit source code to active-low one-hot select.
// Codes above PC decode to the idle select and raise illegal.
module calc_src_decode
    import calc_pkg::*;
(
    input  logic [2:0] src,
    output logic [4:0] sel_n,
    output logic       illegal
);

    always_comb begin
        sel_n   = SEL_NONE;
        illegal = ~src_is_legal(src);
        case (src)
            SRC_R0:  sel_n = SEL_R0;
            SRC_R1:  sel_n = SEL_R1;
            SRC_R2:  sel_n = SEL_R2;
            SRC_R3:  sel_n = SEL_R3;
            SRC_PC:  sel_n = SEL_PC;
            default: sel_n = SEL_NONE;
        endcase
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Sequences one two-operand calculator instruction: operand select, ALU start,
// bounded wait for the result, register write-back and optional PC increment.
//
// state | meaning
// IDLE  | waiting for start; illegal sources rejected here with err
// SEL1  | operand 1 select driven, flag=0
// SEL2  | operand 2 select driven, flag=1
// EXEC  | alu_start pulse
// WAIT  | waiting for alu_done, timeout down-counter running
// WB    | write-back strobe to destination register
// DONE  | done pulse (+ pc_inc), returns to IDLE
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT     = 16,
    parameter int AUTO_PC_INC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        src1,
    input  logic [2:0]        src2,
    input  logic [1:0]        dst,
    input  logic [2:0]        op,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_res,
    output logic [4:0]        choose_reg,
    output logic              flag,
    output logic              alu_start,
    output logic [2:0]        alu_op,
    output logic              wr_en,
    output logic [3:0]        wr_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic              pc_inc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [2:0]        src1_q, src1_d;
    logic [2:0]        src2_q, src2_d;
    logic [1:0]        dst_q, dst_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0]        choose_reg_q, choose_reg_d;
    logic              flag_q, flag_d;
    logic              alu_start_q, alu_start_d;
    logic              wr_en_q, wr_en_d;
    logic [3:0]        wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              pc_inc_q, pc_inc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [2:0]        dec1_src, dec2_src;
    logic [4:0]        sel1_n, sel2_n;
    logic              ill1, ill2;

    // In IDLE the decoders check the live request; afterwards they decode the captured sources.
    assign dec1_src = (state_q == IDLE) ? src1 : src1_q;
    assign dec2_src = (state_q == IDLE) ? src2 : src2_q;

    calc_src_decode u_dec1 (
        .src     (dec1_src),
        .sel_n   (sel1_n),
        .illegal (ill1)
    );

    calc_src_decode u_dec2 (
        .src     (dec2_src),
        .sel_n   (sel2_n),
        .illegal (ill2)
    );

    always_comb begin
        state_d = state_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        dst_d   = dst_q;
        op_d    = op_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ill1 || ill2) begin
                        err_d = 1'b1;
                    end else begin
                        src1_d  = src1;
                        src2_d  = src2;
                        dst_d   = dst;
                        op_d    = op;
                        state_d = SEL1;
                    end
                end
            end
            SEL1: state_d = SEL2;
            SEL2: state_d = EXEC;
            EXEC: begin
                cnt_d   = CNT_W'(TIMEOUT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    res_d   = alu_res;
                    state_d = WB;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WB:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered: decode from the state being entered.
    always_comb begin
        choose_reg_d = SEL_NONE;
        flag_d       = 1'b0;
        alu_start_d  = 1'b0;
        wr_en_d      = 1'b0;
        wr_sel_d     = 4'b0000;
        wr_data_d    = '0;
        pc_inc_d     = 1'b0;
        done_d       = 1'b0;
        busy_d       = (state_d != IDLE);

        case (state_d)
            SEL1: choose_reg_d = sel1_n;
            SEL2: begin
                choose_reg_d = sel2_n;
                flag_d       = 1'b1;
            end
            EXEC: alu_start_d = 1'b1;
            WB: begin
                wr_en_d   = 1'b1;
                wr_sel_d  = 4'b0001 << dst_q;
                wr_data_d = res_d;
            end
            DONE: begin
                done_d   = 1'b1;
                pc_inc_d = (AUTO_PC_INC != 0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src1_q       <= '0;
            src2_q       <= '0;
            dst_q        <= '0;
            op_q         <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            choose_reg_q <= SEL_NONE;
            flag_q       <= 1'b0;
            alu_start_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
            wr_data_q    <= '0;
            pc_inc_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            dst_q        <= dst_d;
            op_q         <= op_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            choose_reg_q <= choose_reg_d;
            flag_q       <= flag_d;
            alu_start_q  <= alu_start_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_data_q    <= wr_data_d;
            pc_inc_q     <= pc_inc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign choose_reg = choose_reg_q;
    assign flag       = flag_q;
    assign alu_start  = alu_start_q;
    assign alu_op     = op_q;
    assign wr_en      = wr_en_q;
    assign wr_sel     = wr_sel_q;
    assign wr_data    = wr_data_q;
    assign pc_inc     = pc_inc_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: cycle-timeline reference model compared every cycle,
// plus directed literal checks on the key scenarios.
module tb_calc_op_sequencer;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] src1, src2, op;
    logic [1:0] dst;
    logic       alu_done;
    logic [7:0] alu_res;
    logic [4:0] choose_reg;
    logic       flag, alu_start, wr_en, pc_inc, busy, done, err;
    logic [2:0] alu_op;
    logic [3:0] wr_sel;
    logic [7:0] wr_data;

    int n_checks = 0;
    int n_pass   = 0;

    calc_op_sequencer #(.DATA_W(8), .TIMEOUT(TIMEOUT), .AUTO_PC_INC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src1       (src1),
        .src2       (src2),
        .dst        (dst),
        .op         (op),
        .alu_done   (alu_done),
        .alu_res    (alu_res),
        .choose_reg (choose_reg),
        .flag       (flag),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .pc_inc     (pc_inc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [4:0] code(input logic [2:0] s);
        case (s)
            3'd0:    return 5'b11110;
            3'd1:    return 5'b11101;
            3'd2:    return 5'b11011;
            3'd3:    return 5'b10111;
            3'd4:    return 5'b01111;
            default: return 5'b11111;
        endcase
    endfunction

    // Reference model: outputs as a function of edges elapsed since the accepting edge.
    int         e = 0;
    bit         m_valid = 1'b0;
    bit         m_act = 1'b0;
    int         m_acc, m_wb, k;
    logic [2:0] m_s1, m_s2, m_op = 3'd0;
    logic [1:0] m_d;
    logic [7:0] m_res;
    logic [4:0] ex_choose;
    logic       ex_flag, ex_start, ex_wr, ex_pc, ex_busy, ex_done, ex_err;
    logic [3:0] ex_sel;
    logic [7:0] ex_data;

    always @(posedge clk) begin
        e++;
        ex_choose = 5'b11111; ex_flag = 0; ex_start = 0; ex_wr = 0; ex_sel = 0;
        ex_data = 0; ex_pc = 0; ex_busy = 0; ex_done = 0; ex_err = 0;
        if (!rst_n) begin
            m_valid = 1; m_act = 0; m_op = 0;
        end else if (!m_act) begin
            if (start) begin
                if (src1 > 3'd4 || src2 > 3'd4) ex_err = 1;
                else begin
                    m_act = 1; m_acc = e; m_wb = -1;
                    m_s1 = src1; m_s2 = src2; m_d = dst; m_op = op;
                end
            end
        end else begin
            k = e - m_acc;
            if (m_wb < 0 && k >= 4) begin
                if (alu_done) begin m_wb = e; m_res = alu_res; end
                else if (k - 3 == TIMEOUT) begin m_act = 0; ex_err = 1; end
            end
            if (m_wb >= 0 && e == m_wb + 2) m_act = 0;
        end
        if (m_act) begin
            k = e - m_acc;
            ex_busy = 1;
            if (k == 0) ex_choose = code(m_s1);
            else if (k == 1) begin ex_choose = code(m_s2); ex_flag = 1; end
            else if (k == 2) ex_start = 1;
            else if (e == m_wb) begin ex_wr = 1; ex_sel = 4'b0001 << m_d; ex_data = m_res; end
            else if (m_wb >= 0 && e == m_wb + 1) begin ex_done = 1; ex_pc = 1; end
        end
    end

    always @(negedge clk) begin
        if (m_valid)
            chk("cycle_outputs",
                {5'd0, choose_reg, flag, alu_start, alu_op, wr_en, wr_sel, wr_data, pc_inc, busy, done, err},
                {5'd0, ex_choose, ex_flag, ex_start, m_op, ex_wr, ex_sel, ex_data, ex_pc, ex_busy, ex_done, ex_err});
    end

    task automatic run_op(input logic [2:0] s1, input logic [2:0] s2, input logic [1:0] d,
                          input logic [2:0] o, input logic [7:0] res, input int extra,
                          input bit start_in_done, input bit early_done);
        start = 1; src1 = s1; src2 = s2; dst = d; op = o;
        @(negedge clk);
        start = 0;
        chk("sel1_code", choose_reg, code(s1));
        chk("sel1_flag", flag, 1'b0);
        if (early_done) begin alu_done = 1; alu_res = ~res; end
        @(negedge clk);
        chk("sel2_code", choose_reg, code(s2));
        chk("sel2_flag", flag, 1'b1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < extra; i++) begin
            alu_done = 0;
            if (i == 1) begin start = 1; src1 = 3'd2; src2 = 3'd1; end
            @(negedge clk);
            start = 0;
        end
        alu_done = 1; alu_res = res;
        @(negedge clk);
        alu_done = 0; alu_res = 8'h00;
        chk("wb_data", wr_data, res);
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        if (start_in_done) begin start = 1; src1 = 3'd1; src2 = 3'd1; end
        @(negedge clk);
        start = 0;
        if (start_in_done) begin
            @(negedge clk);
            chk("drop_start_in_done", busy, 1'b0);
        end
    endtask

    initial begin
        rst_n = 0; start = 0; src1 = 0; src2 = 0; dst = 0; op = 0; alu_done = 0; alu_res = 0;
        repeat (2) @(negedge clk);
        chk("rst_choose", choose_reg, 5'b11111);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_sel", wr_sel, 4'b0000);
        rst_n = 1;
        @(negedge clk);

        // Normal: R0 op R3 -> R2, result 5A
        start = 1; src1 = 3'd0; src2 = 3'd3; dst = 2'd2; op = 3'd5;
        @(negedge clk);
        start = 0;
        chk("n_c1_choose", choose_reg, 5'b11110);
        chk("n_c1_flag", flag, 1'b0);
        @(negedge clk);
        chk("n_c2_choose", choose_reg, 5'b10111);
        chk("n_c2_flag", flag, 1'b1);
        @(negedge clk);
        chk("n_c3_alu_start", alu_start, 1'b1);
        chk("n_c3_alu_op", alu_op, 3'd5);
        @(negedge clk);
        alu_done = 1; alu_res = 8'h5A;
        @(negedge clk);
        alu_done = 0; alu_res = 8'h00;
        chk("n_c5_wr_en", wr_en, 1'b1);
        chk("n_c5_wr_sel", wr_sel, 4'b0100);
        chk("n_c5_wr_data", wr_data, 8'h5A);
        @(negedge clk);
        chk("n_c6_done", done, 1'b1);
        chk("n_c6_pc_inc", pc_inc, 1'b1);
        chk("n_c6_err", err, 1'b0);
        @(negedge clk);
        chk("n_c7_busy", busy, 1'b0);

        // PC operands, back-to-back ops, start in DONE, early alu_done, start during WAIT
        run_op(3'd4, 3'd4, 2'd0, 3'd1, 8'hC3, 0, 0, 0);
        run_op(3'd1, 3'd1, 2'd3, 3'd7, 8'hFF, 0, 1, 0);
        run_op(3'd2, 3'd0, 2'd1, 3'd2, 8'h01, 0, 0, 1);
        run_op(3'd3, 3'd2, 2'd0, 3'd4, 8'h80, 5, 0, 0);

        // Illegal sources
        start = 1; src1 = 3'd6; src2 = 3'd0;
        @(negedge clk);
        start = 0;
        chk("ill_err", err, 1'b1);
        chk("ill_busy", busy, 1'b0);
        chk("ill_choose", choose_reg, 5'b11111);
        @(negedge clk);
        chk("ill_err_clear", err, 1'b0);
        start = 1; src1 = 3'd1; src2 = 3'd7;
        @(negedge clk);
        start = 0;
        chk("ill2_err", err, 1'b1);
        @(negedge clk);

        // Timeout
        start = 1; src1 = 3'd1; src2 = 3'd2; dst = 2'd3; op = 3'd2;
        @(negedge clk);
        start = 0;
        repeat (18) @(negedge clk);
        chk("to_c19_err", err, 1'b0);
        chk("to_c19_busy", busy, 1'b1);
        @(negedge clk);
        chk("to_c20_err", err, 1'b1);
        chk("to_c20_busy", busy, 1'b0);
        chk("to_c20_wr_en", wr_en, 1'b0);
        @(negedge clk);
        chk("to_err_clear", err, 1'b0);

        // Reset during WAIT
        start = 1; src1 = 3'd0; src2 = 3'd1; dst = 2'd1; op = 3'd3;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("rw_busy", busy, 1'b0);
        chk("rw_wr_en", wr_en, 1'b0);
        alu_done = 1; alu_res = 8'h77;
        @(negedge clk);
        alu_done = 0;
        chk("rw_no_wr", wr_en, 1'b0);
        @(negedge clk);
        chk("rw_no_done", done, 1'b0);

        run_op(3'd0, 3'd2, 2'd2, 3'd6, 8'h3C, 2, 0, 0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
